vec_activation_stream: RTL

// Streaming, mode-selectable elementwise activation unit for the inference datapath.

---
 rtl/vec_activation_stream.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vec_activation_stream.sv
// Streaming elementwise activation (PASS/RELU/LEAKY/CLIP) with valid/ready handshaking,
// vector framing and a per-vector count of lanes changed by the activation.
module vec_activation_stream #(
  parameter int InVecLength = 64,
  parameter int WorkingRegs = 4,
  parameter int DataWidth   = 8,
  parameter int LeakyShift  = 3
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [1:0]                       mode_in,
  input  logic [DataWidth-1:0]             clip_in,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WorkingRegs*DataWidth-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WorkingRegs*DataWidth-1:0] out_data,
  output logic                             out_last,
  output logic [$clog2(InVecLength+1)-1:0] mod_count,
  output logic                             vec_done,
  output logic                             busy
);

  localparam int NumChunks = InVecLength / WorkingRegs;
  localparam int IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int CntW      = $clog2(InVecLength + 1);
  localparam int LaneCntW  = $clog2(WorkingRegs + 1);

  generate
    if (InVecLength % WorkingRegs != 0) begin : g_bad_len
      $error("InVecLength must be a multiple of WorkingRegs");
    end
  endgenerate

  typedef enum logic [1:0] {PASS = 2'd0, RELU = 2'd1, LEAKY = 2'd2, CLIP = 2'd3} act_mode_t;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                     state_reg, state_next;
  logic [IdxW-1:0]            idx_reg, idx_next;
  act_mode_t                  mode_reg, mode_next;
  logic signed [DataWidth-1:0] clip_reg, clip_next;

  logic                       out_valid_reg;
  logic [WorkingRegs*DataWidth-1:0] out_data_reg;
  logic                       out_last_reg;
  logic [CntW-1:0]            mod_count_reg;
  logic [CntW-1:0]            acc_reg;
  logic                       vec_done_reg;
  logic                       busy_reg;

  logic                       accept;
  logic                       drain;
  logic                       chunk_last;
  act_mode_t                  cur_mode;
  logic signed [DataWidth-1:0] cur_clip;
  logic [WorkingRegs*DataWidth-1:0] y_packed;
  logic [WorkingRegs-1:0]     lane_mod;
  logic [LaneCntW-1:0]        lane_cnt;

  // Reset also gates ready so nothing is accepted while the unit is being cleared.
  assign in_ready   = !rst_in && (!out_valid_reg || out_ready);
  assign accept     = in_valid && in_ready;
  assign drain      = out_valid_reg && out_ready;
  assign chunk_last = (idx_reg == IdxW'(NumChunks - 1));

  // The first chunk of a vector uses the live mode/clip; later chunks use the latched copy.
  assign cur_mode = (state_reg == IDLE) ? act_mode_t'(mode_in) : mode_reg;
  assign cur_clip = (state_reg == IDLE) ? $signed(clip_in) : clip_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WorkingRegs; gi++) begin : g_lane
      logic signed [DataWidth-1:0] x;
      logic signed [DataWidth-1:0] y;
      assign x = $signed(in_data[gi*DataWidth +: DataWidth]);

      always_comb begin
        y = x;
        case (cur_mode)
          PASS:  y = x;
          RELU:  y = x[DataWidth-1] ? '0 : x;
          LEAKY: y = x[DataWidth-1] ? (x >>> LeakyShift) : x;
          CLIP: begin
            if (x[DataWidth-1])   y = '0;
            else if (x > cur_clip) y = cur_clip;
            else                   y = x;
          end
          default: y = x;
        endcase
      end

      assign y_packed[gi*DataWidth +: DataWidth] = y;
      assign lane_mod[gi] = (y != x);
    end
  endgenerate

  always_comb begin
    lane_cnt = '0;
    for (int i = 0; i < WorkingRegs; i++) begin
      lane_cnt = lane_cnt + LaneCntW'(lane_mod[i]);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      mode_reg  <= PASS;
      clip_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      mode_reg  <= mode_next;
      clip_reg  <= clip_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    mode_next  = mode_reg;
    clip_next  = clip_reg;
    if (accept) begin
      if (state_reg == IDLE) begin
        mode_next = act_mode_t'(mode_in);
        clip_next = $signed(clip_in);
      end
      if (chunk_last) begin
        idx_next   = '0;
        state_next = IDLE;
      end else begin
        idx_next   = idx_reg + IdxW'(1);
        state_next = RUN;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      mod_count_reg <= '0;
      acc_reg       <= '0;
      vec_done_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      // A simultaneous drain and accept simply reloads the register.
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= y_packed;
        out_last_reg  <= chunk_last;
        if (chunk_last) begin
          mod_count_reg <= acc_reg + CntW'(lane_cnt);
          acc_reg       <= '0;
        end else begin
          mod_count_reg <= '0;
          acc_reg       <= acc_reg + CntW'(lane_cnt);
        end
      end else if (drain) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
        mod_count_reg <= '0;
      end
      vec_done_reg <= drain && out_last_reg;
      if (accept && state_reg == IDLE) busy_reg <= 1'b1;
      else if (drain && out_last_reg)  busy_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign mod_count = mod_count_reg;
  assign vec_done  = vec_done_reg;
  assign busy      = busy_reg;

endmodule
